key_load_ctrl: RTL and testbench

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

---
 rtl/key_load_pkg.sv | 17 +
 rtl/key_load_ctrl_if.sv | 23 ++
 rtl/key_shadow_sr.sv | 37 +++
 rtl/key_load_ctrl.sv | 98 +++++++++
 tb/tb_key_load_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/key_load_pkg.sv
// Shared sizing and FSM state type for the serial key loader.
package key_load_pkg;

  localparam int unsigned KEY_W    = 16;
  localparam int unsigned MAX_FAIL = 3;
  localparam int unsigned IDX_W    = $clog2(KEY_W);
  // One extra count for the trailing parity beat.
  localparam int unsigned CNT_W    = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck,
    StCommit
  } state_e;

endpackage

// File: rtl/key_load_ctrl_if.sv
// Serial key-load handshake between a key source and the loader.
interface key_load_ctrl_if;

  logic load_start;
  logic key_bit;
  logic key_valid;
  logic key_ready;

  modport master (
    output load_start,
    output key_bit,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  load_start,
    input  key_bit,
    input  key_valid,
    output key_ready
  );

endinterface

// File: rtl/key_shadow_sr.sv
// Shadow register, beat counter and running parity for one serial key load.
module key_shadow_sr
  import key_load_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic             last_beat,
  output logic             parity_err
);

  logic [CNT_W-1:0] beat_cnt;
  logic             parity;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shadow   <= '0;
      beat_cnt <= '0;
      parity   <= 1'b0;
    end else if (shift_en) begin
      if (beat_cnt < CNT_W'(KEY_W)) begin
        shadow[beat_cnt[IDX_W-1:0]] <= bit_in;
      end
      beat_cnt <= beat_cnt + CNT_W'(1);
      parity   <= parity ^ bit_in;
    end
  end

  // Next accepted beat is the parity bit.
  assign last_beat  = (beat_cnt == CNT_W'(KEY_W));
  // XOR over data and parity beats; nonzero means the even-parity check failed.
  assign parity_err = parity;

endmodule

// File: rtl/key_load_ctrl.sv
// Serial key loader: shifts in a key plus even parity, commits it atomically to key_out.
module key_load_ctrl
  import key_load_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  key_load_ctrl_if.slave   bus,
  output logic [KEY_W-1:0] key_out,
  output logic             key_applied,
  output logic             busy,
  output logic             err,
  output logic [1:0]       fail_cnt,
  output logic             lockout
);

  state_e           state_q;
  logic             ready_q;
  logic [KEY_W-1:0] shadow;
  logic             last_beat;
  logic             parity_err;
  logic             clear;
  logic             shift_en;

  assign bus.key_ready = ready_q;

  // A start pulse restarts the shadow only where a load may (re)begin.
  assign clear    = bus.load_start && ((state_q == StIdle && !lockout) || state_q == StShift);
  assign shift_en = bus.key_valid && ready_q && !bus.load_start;

  key_shadow_sr u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .shift_en   (shift_en),
    .bit_in     (bus.key_bit),
    .shadow     (shadow),
    .last_beat  (last_beat),
    .parity_err (parity_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      key_out     <= '0;
      key_applied <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      fail_cnt    <= '0;
      lockout     <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load_start && !lockout) begin
            state_q <= StShift;
            ready_q <= 1'b1;
            busy    <= 1'b1;
          end
        end
        StShift: begin
          if (shift_en && last_beat) begin
            state_q <= StCheck;
            ready_q <= 1'b0;
          end
        end
        StCheck: begin
          if (!parity_err) begin
            state_q <= StCommit;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
            err     <= 1'b1;
            if (fail_cnt != 2'(MAX_FAIL)) begin
              fail_cnt <= fail_cnt + 2'd1;
            end
            if (fail_cnt == 2'(MAX_FAIL - 1)) begin
              lockout <= 1'b1;
            end
          end
        end
        StCommit: begin
          state_q     <= StIdle;
          busy        <= 1'b0;
          key_out     <= shadow;
          key_applied <= 1'b1;
          fail_cnt    <= '0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl with a transaction-level reference model.
module tb_key_load_ctrl;
  import key_load_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        key_bit;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] key_out;
  logic        key_applied;
  logic        busy;
  logic        err;
  logic [1:0]  fail_cnt;
  logic        lockout;

  key_load_ctrl_if bus_if ();

  assign bus_if.load_start = load_start;
  assign bus_if.key_bit    = key_bit;
  assign bus_if.key_valid  = key_valid;
  assign key_ready         = bus_if.key_ready;

  key_load_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .key_out     (key_out),
    .key_applied (key_applied),
    .busy        (busy),
    .err         (err),
    .fail_cnt    (fail_cnt),
    .lockout     (lockout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;
  bit err_seen = 0;

  // Reference model: a load collects KEY_W data bits then a parity bit; the verdict
  // is reached one edge later and a good key is published one edge after that.
  bit          m_loading;
  int          m_beats;
  logic [15:0] m_acc;
  logic        m_par;
  int          m_since_parity;
  logic [15:0] m_key;
  bit          m_applied;
  bit          m_err;
  int          m_fail;
  bit          m_lock;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_loading = 0; m_beats = 0; m_acc = '0; m_par = 0; m_since_parity = 0;
      m_key = '0; m_applied = 0; m_err = 0; m_fail = 0; m_lock = 0;
    end else begin
      m_err = 0;
      if (m_since_parity == 1) begin
        if ((^m_acc) == m_par) begin
          m_since_parity = 2;
        end else begin
          m_err = 1;
          if (m_fail < MAX_FAIL) m_fail++;
          if (m_fail >= MAX_FAIL) m_lock = 1;
          m_since_parity = 0;
        end
      end else if (m_since_parity == 2) begin
        m_key = m_acc; m_applied = 1; m_fail = 0; m_since_parity = 0;
      end else if (m_loading) begin
        if (load_start) begin
          m_beats = 0; m_acc = '0;
        end else if (key_valid) begin
          if (m_beats < KEY_W) begin
            m_acc[m_beats] = key_bit;
            m_beats++;
          end else begin
            m_par = key_bit; m_loading = 0; m_since_parity = 1;
          end
        end
      end else if (load_start && !m_lock) begin
        m_loading = 1; m_beats = 0; m_acc = '0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        if (err === 1'b1) err_seen = 1;
        chk("key_out",     32'(key_out),     32'(m_key));
        chk("key_applied", 32'(key_applied), 32'(m_applied));
        chk("busy",        32'(busy),        32'(m_loading || m_since_parity != 0));
        chk("key_ready",   32'(key_ready),   32'(m_loading));
        chk("err",         32'(err),         32'(m_err));
        chk("fail_cnt",    32'(fail_cnt),    32'(m_fail));
        chk("lockout",     32'(lockout),     32'(m_lock));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step(1);
    load_start = 1'b0;
  endtask

  // Send beats 0..n-1 of w (w[16] is the parity beat); gap idles key_valid between beats.
  task automatic send_bits(input logic [16:0] w, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_bit   = w[i];
      step(1);
      if (gap) begin
        key_valid = 1'b0;
        step(1);
      end
    end
    key_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
    step(2);
    check_en = 1;
    chk("rst_key_out", 32'(key_out), 32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_lockout", 32'(lockout), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Back-to-back good load; key_out must hold its old value through the check edge.
    err_seen = 0;
    start_load();
    send_bits({1'b0, 16'hA5C3}, 17, 1'b0);
    step(1);
    chk("a5c3_not_yet", 32'(key_out), 32'h0);
    step(1);
    chk("a5c3_key",     32'(key_out), 32'hA5C3);
    chk("a5c3_applied", 32'(key_applied), 32'h1);
    step(1);
    chk("a5c3_no_err",  32'(err_seen), 32'h0);

    // Bad parity: one err pulse, key_out kept.
    start_load();
    send_bits({1'b0, 16'h0001}, 17, 1'b0);
    step(1);
    chk("bad_err",      32'(err),      32'h1);
    chk("bad_fail_cnt", 32'(fail_cnt), 32'h1);
    step(1);
    chk("bad_err_pulse", 32'(err),     32'h0);
    chk("bad_key_kept",  32'(key_out), 32'hA5C3);
    step(1);

    // Stalled beats; 0x1234 has five ones so its even-parity bit is 1.
    start_load();
    send_bits({1'b1, 16'h1234}, 17, 1'b1);
    step(3);
    chk("gap_key",      32'(key_out),  32'h1234);
    chk("gap_fail_clr", 32'(fail_cnt), 32'h0);

    // Restart mid-load (beat offered with the restart must be dropped), then start
    // pulses during the check and commit cycles must be ignored.
    start_load();
    send_bits({1'b0, 16'hFFFF}, 8, 1'b0);
    load_start = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
    step(1);
    load_start = 1'b0; key_valid = 1'b0;
    send_bits({1'b0, 16'h00F0}, 17, 1'b0);
    load_start = 1'b1;
    step(2);
    load_start = 1'b0;
    step(1);
    chk("restart_key",  32'(key_out), 32'h00F0);
    chk("restart_idle", 32'(busy),    32'h0);

    // Reset after beat 10 discards the partial key.
    start_load();
    send_bits({1'b1, 16'hBEEF}, 11, 1'b0);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_key",     32'(key_out),     32'h0);
    chk("mid_rst_applied", 32'(key_applied), 32'h0);
    chk("mid_rst_busy",    32'(busy),        32'h0);
    chk("mid_rst_ready",   32'(key_ready),   32'h0);
    rst_n = 1'b1;
    step(1);
    // 0xBEEF has thirteen ones, so its even-parity bit is 1.
    start_load();
    send_bits({1'b1, 16'hBEEF}, 17, 1'b0);
    step(3);
    chk("beef_key", 32'(key_out), 32'hBEEF);

    // Three consecutive parity failures lock the loader.
    for (int k = 0; k < 3; k++) begin
      start_load();
      send_bits({1'b0, 16'h0001}, 17, 1'b0);
      step(3);
    end
    chk("lock_set",      32'(lockout),  32'h1);
    chk("lock_fail_cnt", 32'(fail_cnt), 32'h3);
    start_load();
    chk("lock_no_busy",  32'(busy),      32'h0);
    chk("lock_no_ready", 32'(key_ready), 32'h0);
    chk("lock_key_kept", 32'(key_out),   32'hBEEF);
    step(2);

    rst_n = 1'b0;
    step(1);
    chk("lock_cleared", 32'(lockout), 32'h0);
    rst_n = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
